uart_receiver: RTL

Serial receive front end for the memory-mapped peripheral block. Oversamples the `UART_RX` pin at 16× the baud rate, frames 8N1 characters (LSB first), and presents each received byte with a valid/acknowledge handshake. The peripheral register file consumes `rx_data` and `rx_valid` and returns `rx_ack` when software reads the RX data register. Framing and overrun errors are also reported.

---
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 16x oversampled UART receive front end (8N1) with valid/ack handshake and sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_receiver #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_done,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_n;
   logic          sync1, sync2, prev;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [3:0]    s_cnt, s_cnt_n;
   logic [2:0]    b_cnt, b_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          good, ferr_ev;
   logic          ack_eff;
`ifdef UART_RX_PARITY_EN
   logic          perr_ev;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= UART_RX;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         s_cnt <= '0;
         b_cnt <= '0;
         shreg <= '0;
      end else begin
         state <= state_n;
         s_cnt <= s_cnt_n;
         b_cnt <= b_cnt_n;
         shreg <= shreg_n;
      end
   end

   always_comb begin
      state_n = state;
      s_cnt_n = s_cnt;
      b_cnt_n = b_cnt;
      shreg_n = shreg;
      good    = 1'b0;
      ferr_ev = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_ev = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            // IDLE needs a true falling edge, so a held-low break never retriggers
            if (prev && !sync2) begin
               state_n = START;
               s_cnt_n = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt == 4'd7) begin
                  if (!sync2) begin
                     state_n = DATA;
                     s_cnt_n = '0;
                     b_cnt_n = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt_n = '0;
                  shreg_n = {sync2, shreg[7:1]};
                  b_cnt_n = b_cnt + 3'd1;
                  if (b_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt_n = '0;
                  perr_ev = ^{shreg, sync2};
                  state_n = STOP;
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt_n = '0;
                  if (sync2)
                     good = 1'b1;
                  else
                     ferr_ev = 1'b1;
                  state_n = IDLE;
               end else begin
                  s_cnt_n = s_cnt + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign ack_eff = rx_ack & rx_valid;

   // A new byte coinciding with an ack keeps valid high and does not count as overrun
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_done   <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (good)
            rx_data <= shreg;
         rx_valid  <= good | (rx_valid & ~rx_ack);
         rx_done   <= good;
         rx_busy   <= (state_n != IDLE);
         frame_err <= (frame_err & ~ack_eff) | ferr_ev;
         overrun   <= (overrun & ~ack_eff) | (good & rx_valid & ~rx_ack);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         parity_err <= 1'b0;
      else
         parity_err <= (parity_err & ~ack_eff) | perr_ev;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
